// File: rtl/maxunpool1d.sv
// 1-D max-unpooling: each pooled (value, index) pair expands into a KERNEL_SIZE-beat
// window where only the beat at the stored index carries the value; all others are zero.

module maxunpool1d_param_chk #(
    parameter int DATA_IN_0_PRECISION_0        = 8,
    parameter int DATA_IN_0_PRECISION_1        = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 4,
    parameter int KERNEL_SIZE                  = 2,
    parameter int STRIDE                       = 2,
    parameter int DATA_OUT_0_PRECISION_0       = 8,
    parameter int DATA_OUT_0_PRECISION_1       = 3,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 8
) ();
    if (KERNEL_SIZE < 2) begin : g_bad_kernel
        $error("maxunpool1d: KERNEL_SIZE must be at least 2");
    end
    if (STRIDE != KERNEL_SIZE) begin : g_bad_stride
        $error("maxunpool1d: STRIDE must equal KERNEL_SIZE");
    end
    if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0) begin : g_bad_width
        $error("maxunpool1d: output width must equal input width");
    end
    if (DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : g_bad_frac
        $error("maxunpool1d: output fractional bits must equal input fractional bits");
    end
    if (DATA_OUT_0_TENSOR_SIZE_DIM_0 != DATA_IN_0_TENSOR_SIZE_DIM_0 * KERNEL_SIZE) begin : g_bad_len
        $error("maxunpool1d: output length must equal input length times KERNEL_SIZE");
    end
endmodule

module maxunpool1d #(
    parameter int DATA_IN_0_PRECISION_0        = 8,
    parameter int DATA_IN_0_PRECISION_1        = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 4,
    parameter int KERNEL_SIZE                  = 2,
    parameter int STRIDE                       = 2,
    parameter int DATA_OUT_0_PRECISION_0       = 8,
    parameter int DATA_OUT_0_PRECISION_1       = 3,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 8,
    localparam int IDX_W = ($clog2(KERNEL_SIZE) > 1) ? $clog2(KERNEL_SIZE) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic [IDX_W-1:0]                  indices_in_0,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic                              data_out_0_last,
    output logic                              index_err
);
    localparam int DW    = DATA_IN_0_PRECISION_0;
    localparam int WIN_W = ($clog2(DATA_IN_0_TENSOR_SIZE_DIM_0) > 1) ? $clog2(DATA_IN_0_TENSOR_SIZE_DIM_0) : 1;
    localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(KERNEL_SIZE - 1);
    localparam logic [IDX_W:0]   K_EXT   = (IDX_W + 1)'(KERNEL_SIZE);
    localparam logic [WIN_W-1:0] W_LAST  = WIN_W'(DATA_IN_0_TENSOR_SIZE_DIM_0 - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    maxunpool1d_param_chk #(
        .DATA_IN_0_PRECISION_0       (DATA_IN_0_PRECISION_0),
        .DATA_IN_0_PRECISION_1       (DATA_IN_0_PRECISION_1),
        .DATA_IN_0_TENSOR_SIZE_DIM_0 (DATA_IN_0_TENSOR_SIZE_DIM_0),
        .KERNEL_SIZE                 (KERNEL_SIZE),
        .STRIDE                      (STRIDE),
        .DATA_OUT_0_PRECISION_0      (DATA_OUT_0_PRECISION_0),
        .DATA_OUT_0_PRECISION_1      (DATA_OUT_0_PRECISION_1),
        .DATA_OUT_0_TENSOR_SIZE_DIM_0(DATA_OUT_0_TENSOR_SIZE_DIM_0)
    ) u_param_chk ();

    state_t            state_r, state_s;
    logic [IDX_W-1:0]  k_r, k_s;
    logic [WIN_W-1:0]  w_r, w_s;
    logic [DW-1:0]     val_r, val_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic              err_r, err_s;
    logic [DW-1:0]     dout_r, dout_s;
    logic              vld_r, vld_s;
    logic              last_r, last_s;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              idx_oor_s;

    // Input acceptance: the next window is taken only as the current one's final beat leaves.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (state_r == EMIT) begin
            in_ready_s = data_out_0_ready && (k_r == K_LAST);
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign in_fire_s  = data_in_0_valid && in_ready_s;
    assign out_fire_s = vld_r && data_out_0_ready;
    assign idx_oor_s  = ({1'b0, indices_in_0} >= K_EXT);

    // Next-state, beat/window counters and the registered output image of the next cycle.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        w_s     = w_r;
        val_s   = val_r;
        idx_s   = idx_r;
        err_s   = err_r || (in_fire_s && idx_oor_s);
        case (state_r)
            IDLE: begin
                if (in_fire_s) begin
                    val_s   = data_in_0;
                    idx_s   = indices_in_0;
                    k_s     = {IDX_W{1'b0}};
                    state_s = EMIT;
                end else begin
                    state_s = IDLE;
                end
            end
            EMIT: begin
                if (out_fire_s) begin
                    if (k_r == K_LAST) begin
                        w_s = (w_r == W_LAST) ? {WIN_W{1'b0}} : (w_r + WIN_W'(1));
                        k_s = {IDX_W{1'b0}};
                        if (in_fire_s) begin
                            val_s   = data_in_0;
                            idx_s   = indices_in_0;
                            state_s = EMIT;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        k_s = k_r + IDX_W'(1);
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s = IDLE;
                k_s     = {IDX_W{1'b0}};
            end
        endcase

        // An out-of-range index never equals k, so that window emits only zeros.
        vld_s  = (state_s == EMIT);
        last_s = vld_s && (k_s == K_LAST) && (w_s == W_LAST);
        dout_s = (vld_s && (k_s == idx_s)) ? val_s : {DW{1'b0}};
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            k_r     <= {IDX_W{1'b0}};
            w_r     <= {WIN_W{1'b0}};
            val_r   <= {DW{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            err_r   <= 1'b0;
            dout_r  <= {DW{1'b0}};
            vld_r   <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            w_r     <= w_s;
            val_r   <= val_s;
            idx_r   <= idx_s;
            err_r   <= err_s;
            dout_r  <= dout_s;
            vld_r   <= vld_s;
            last_r  <= last_s;
        end
    end

    assign data_in_0_ready  = in_ready_s;
    assign data_out_0       = dout_r;
    assign data_out_0_valid = vld_r;
    assign data_out_0_last  = last_r;
    assign index_err        = err_r;

endmodule

// File: tb/tb_maxunpool1d.sv
// Randomized and directed bench for maxunpool1d (K=2 and K=3 instances) checked against
// a queue-based window-expansion reference model.

module tb_maxunpool1d;
    localparam int DW = 8;
    localparam int K1 = 2;
    localparam int D1 = 4;
    localparam int K2 = 3;
    localparam int D2 = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] in_data;
    logic [0:0]    in_idx;
    logic          in_valid, in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready, out_last, idx_err;

    logic [DW-1:0] in2_data;
    logic [1:0]    in2_idx;
    logic          in2_valid, in2_ready;
    logic [DW-1:0] out2_data;
    logic          out2_valid, out2_ready, out2_last, err2;

    maxunpool1d dut1 (
        .clk(clk), .rst(rst),
        .data_in_0(in_data), .indices_in_0(in_idx),
        .data_in_0_valid(in_valid), .data_in_0_ready(in_ready),
        .data_out_0(out_data), .data_out_0_valid(out_valid),
        .data_out_0_ready(out_ready), .data_out_0_last(out_last),
        .index_err(idx_err)
    );

    maxunpool1d #(
        .KERNEL_SIZE(K2), .STRIDE(K2), .DATA_OUT_0_TENSOR_SIZE_DIM_0(D2 * K2)
    ) dut2 (
        .clk(clk), .rst(rst),
        .data_in_0(in2_data), .indices_in_0(in2_idx),
        .data_in_0_valid(in2_valid), .data_in_0_ready(in2_ready),
        .data_out_0(out2_data), .data_out_0_valid(out2_valid),
        .data_out_0_ready(out2_ready), .data_out_0_last(out2_last),
        .index_err(err2)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic rnd_ready = 1'b0;

    beat_t         q1[$], q2[$];
    logic [DW-1:0] log1[$], log2[$];
    int            cyc_log[$];
    int            last_pos[$];
    int            cyc = 0;
    int            win1 = 0, win2 = 0, beats1 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: a window (v,i) of kernel k expands to k beats, v at beat i (if i<k), else 0.
    function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] v, input int i, input int j, input int k);
        return (i < k && j == i) ? v : 8'h00;
    endfunction

    // Monitor for dut1: model bookkeeping, beat comparison, stall stability.
    initial begin
        beat_t         b;
        logic          prev_hold;
        logic [DW-1:0] prev_d;
        logic          prev_l;
        prev_hold = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q1.delete(); last_pos.delete();
                win1 = 0; beats1 = 0; prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check_eq("hold_valid", 32'(out_valid), 32'd1);
                    check_eq("hold_data", 32'(out_data), 32'(prev_d));
                    check_eq("hold_last", 32'(out_last), 32'(prev_l));
                end
                if (out_valid && out_ready) begin
                    beats1++;
                    log1.push_back(out_data);
                    cyc_log.push_back(cyc);
                    if (out_last) last_pos.push_back(beats1);
                    check_eq("beat_expected", 32'(q1.size() > 0), 32'd1);
                    if (q1.size() > 0) begin
                        b = q1.pop_front();
                        check_eq("beat_data", 32'(out_data), 32'(b.d));
                        check_eq("beat_last", 32'(out_last), 32'(b.l));
                    end
                end
                if (in_valid && in_ready) begin
                    for (int j = 0; j < K1; j++) begin
                        b.d = ref_beat(in_data, int'(in_idx), j, K1);
                        b.l = (j == K1 - 1) && (win1 == D1 - 1);
                        q1.push_back(b);
                    end
                    win1 = (win1 + 1) % D1;
                end
                prev_hold = out_valid && !out_ready;
                prev_d = out_data;
                prev_l = out_last;
            end
        end
    end

    // Monitor for dut2 (K=3).
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst) begin
                q2.delete(); win2 = 0;
            end else begin
                if (out2_valid && out2_ready) begin
                    log2.push_back(out2_data);
                    check_eq("beat2_expected", 32'(q2.size() > 0), 32'd1);
                    if (q2.size() > 0) begin
                        b = q2.pop_front();
                        check_eq("beat2_data", 32'(out2_data), 32'(b.d));
                        check_eq("beat2_last", 32'(out2_last), 32'(b.l));
                    end
                end
                if (in2_valid && in2_ready) begin
                    for (int j = 0; j < K2; j++) begin
                        b.d = ref_beat(in2_data, int'(in2_idx), j, K2);
                        b.l = (j == K2 - 1) && (win2 == D2 - 1);
                        q2.push_back(b);
                    end
                    win2 = (win2 + 1) % D2;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send1(input logic [DW-1:0] v, input logic i);
        logic ok;
        ok = 1'b0;
        in_data = v; in_idx = i; in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        check_eq("send1_accepted", 32'(ok), 32'd1);
    endtask

    task automatic send2(input logic [DW-1:0] v, input logic [1:0] i);
        logic ok;
        ok = 1'b0;
        in2_data = v; in2_idx = i; in2_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            ok = in2_ready;
            tick();
            if (ok) break;
        end
        in2_valid = 1'b0;
        check_eq("send2_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            done = (q1.size() == 0) && (q2.size() == 0) && !out_valid && !out2_valid;
            if (done) break;
            tick();
        end
        check_eq("drain_done", 32'(done), 32'd1);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int s;
        logic [DW-1:0] exp1 [0:7];
        exp1 = '{8'd0, 8'd5, 8'd9, 8'd0, 8'd0, 8'd3, 8'd7, 8'd0};
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; in_idx = 1'b0;
        in2_valid = 1'b0; in2_data = 8'h00; in2_idx = 2'd0;
        out_ready = 1'b1; out2_ready = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk);
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        check_eq("reset_data", 32'(out_data), 32'd0);
        check_eq("reset_last", 32'(out_last), 32'd0);
        check_eq("reset_err", 32'(idx_err), 32'd0);
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Back-to-back windows, no bubbles, last on 8th beat
        s = log1.size();
        send1(8'd5, 1'b1); send1(8'd9, 1'b0); send1(8'd3, 1'b1); send1(8'd7, 1'b0);
        drain();
        check_eq("t1_count", 32'(log1.size() - s), 32'd8);
        if (log1.size() - s == 8) begin
            for (int j = 0; j < 8; j++) check_eq("t1_stream", 32'(log1[s + j]), 32'(exp1[j]));
            check_eq("t1_no_bubble", 32'(cyc_log[s + 7] - cyc_log[s]), 32'd7);
        end
        check_eq("t1_last_count", 32'(last_pos.size()), 32'd1);
        if (last_pos.size() > 0) check_eq("t1_last_pos", 32'(last_pos[0]), 32'd8);

        // Backpressure during beat k=1
        send1(8'h7F, 1'b1);
        tick();
        out_ready = 1'b0;
        s = log1.size();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("bp_data", 32'(out_data), 32'h7F);
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check_eq("bp_one_xfer", 32'(log1.size() - s), 32'd1);
        if (log1.size() > s) check_eq("bp_xfer_data", 32'(log1[s]), 32'h7F);
        check_eq("bp_idle", 32'(out_valid), 32'd0);
        tick();

        // K=3 instance, out-of-range index
        check_eq("k3_err_init", 32'(err2), 32'd0);
        s = log2.size();
        send2(8'h42, 2'd3);
        drain();
        check_eq("k3_zero_beats", 32'(log2.size() - s), 32'd3);
        for (int j = s; j < log2.size(); j++) check_eq("k3_zero", 32'(log2[j]), 32'd0);
        check_eq("k3_err_set", 32'(err2), 32'd1);
        for (int n = 0; n < 3 + 2 * D2; n++) send2(8'($urandom), 2'($urandom_range(0, 2)));
        drain();
        check_eq("k3_err_sticky", 32'(err2), 32'd1);

        // Reset mid-window
        do_reset();
        @(negedge clk);
        check_eq("rst_err2_clear", 32'(err2), 32'd0);
        tick();
        for (int n = 0; n < 3; n++) send1(8'($urandom), 1'($urandom));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_err", 32'(idx_err), 32'd0);
        tick();
        for (int n = 0; n < D1; n++) send1(8'($urandom), 1'($urandom));
        drain();
        check_eq("mid_rst_last_count", 32'(last_pos.size()), 32'd1);
        if (last_pos.size() > 0) check_eq("mid_rst_last_pos", 32'(last_pos[0]), 32'd8);

        // Negative value passes bit-exact
        s = log1.size();
        send1(8'h80, 1'b0);
        drain();
        check_eq("neg_count", 32'(log1.size() - s), 32'd2);
        if (log1.size() - s == 2) begin
            check_eq("neg_beat0", 32'(log1[s]), 32'h80);
            check_eq("neg_beat1", 32'(log1[s + 1]), 32'h00);
        end

        // Two tensors with random input gaps
        do_reset();
        for (int n = 0; n < 2 * D1; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            send1(8'($urandom), 1'($urandom));
        end
        drain();
        check_eq("gap_last_count", 32'(last_pos.size()), 32'd2);
        if (last_pos.size() == 2) begin
            check_eq("gap_last_8", 32'(last_pos[0]), 32'd8);
            check_eq("gap_last_16", 32'(last_pos[1]), 32'd16);
        end

        // Random stress with random output backpressure
        rnd_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            send1(8'($urandom), 1'($urandom));
        end
        drain();
        rnd_ready = 1'b0;
        out_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
